// File: rtl/psram_pkg.sv
// Shared definitions for the Wishbone-to-PSRAM controller.
//   state_e         controller sequencing states
//   HALF_HI/HALF_LO halfword selector; also the LSB of the PSRAM halfword address
//   powerup_cycles  clock count for the PSRAM power-up hold-off
package psram_pkg;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StAcc,
        StGap,
        StAck
    } state_e;

    // Big-endian split: the upper halfword lives at the even PSRAM address.
    localparam logic HALF_HI = 1'b0;
    localparam logic HALF_LO = 1'b1;

    // Never returns 0 so the timer always has at least one cycle to count.
    function automatic int unsigned powerup_cycles(input int unsigned clk_freq,
                                                   input int unsigned powerup_us);
        int unsigned n;
        n = (clk_freq / 1000000) * powerup_us;
        return (n == 0) ? 1 : n;
    endfunction

endpackage

// File: rtl/psram_powerup_timer.sv
// Power-up hold-off timer. A down-counter loaded by reset; done rises (and stays
// high) once the programmed number of cycles has elapsed.
//   clk     system clock
//   reset_n asynchronous active-low reset; reloads the counter
//   done    registered, high once the hold-off is complete
//   expire  high during the final counting cycle, i.e. done rises on the next edge
module psram_powerup_timer #(
    parameter int unsigned cycles = 50
) (
    input  logic clk,
    input  logic reset_n,
    output logic done,
    output logic expire
);

    localparam int unsigned CW = (cycles < 2) ? 1 : $clog2(cycles + 1);
    localparam logic [CW-1:0] LOAD = CW'(cycles);

    logic [CW-1:0] cnt_q;
    logic          done_q;

    assign expire = !done_q && (cnt_q == CW'(1));
    assign done   = done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= LOAD;
            done_q <= 1'b0;
        end else if (!done_q) begin
            cnt_q <= cnt_q - CW'(1);
            if (expire) begin
                done_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_psram_ctrl.sv
// Wishbone classic slave for the 16-bit asynchronous cellular RAM (PSRAM).
// Each 32-bit cycle is split into up to two timed 16-bit accesses, upper
// halfword first. Accesses are held off until the power-up interval elapses.
//   clk, reset_n          system clock, asynchronous active-low reset
//   wb_*                  Wishbone classic slave (32-bit data, byte selects)
//   ready                 high once the PSRAM power-up hold-off is complete
//   sram_adr              halfword address {wb_adr[23:2], half}
//   sram_dat              bidirectional PSRAM data bus
//   sram_be_n             active-low byte enables, [1] = upper byte
//   sram_ce_n/oe_n/we_n   active-low strobes
//   sram_adv_n/cre/clk    static pins for asynchronous mode, tied low
module wb_psram_ctrl
    import psram_pkg::*;
#(
    parameter int unsigned clk_freq    = 50000000,
    parameter int unsigned powerup_us  = 150,
    parameter int unsigned wait_cycles = 4  // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        ready,
    output logic [22:0] sram_adr,
    inout  wire  [15:0] sram_dat,
    output logic [1:0]  sram_be_n,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_adv_n,
    output logic        sram_cre,
    output logic        sram_clk
);

    localparam int unsigned PWR_CYCLES = powerup_cycles(clk_freq, powerup_us);
    // Counter runs wait_cycles-1 down to 0, so ACC spans wait_cycles clocks.
    localparam logic [3:0] WAIT_LOAD = 4'(wait_cycles - 1);

    state_e      state_q;
    logic [3:0]  wait_q;
    logic [21:0] adr_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic        we_q;
    logic        half_q;
    logic        abort_q;
    logic        ack_q;
    logic [31:0] rdat_q;
    logic [22:0] sram_adr_q;
    logic [1:0]  be_n_q;
    logic        ce_n_q;
    logic        oe_n_q;
    logic        we_n_q;
    logic [15:0] dout_q;
    logic        doe_q;

    logic        pwr_done;
    logic        pwr_expire;

    logic        request;
    logic        req_we;
    logic [21:0] req_adr;
    logic [31:0] req_dat;
    logic [3:0]  req_sel;
    logic        need_hi;
    logic        need_lo;
    logic        launch;
    logic        next_half;
    logic [1:0]  acc_sel;
    logic [1:0]  acc_be_n;
    logic [15:0] acc_dat;

    // Byte-lane and halfword-lane address bits are not used by this slave.
    logic unused_adr;
    assign unused_adr = ^{wb_adr_i[31:24], wb_adr_i[1:0]};

    psram_powerup_timer #(
        .cycles (PWR_CYCLES)
    ) u_powerup (
        .clk     (clk),
        .reset_n (reset_n),
        .done    (pwr_done),
        .expire  (pwr_expire)
    );

    // In IDLE the access is launched from the live bus on the sampling edge;
    // in GAP the second half is launched from the latched request.
    always_comb begin
        req_we  = we_q;
        req_adr = adr_q;
        req_dat = dat_q;
        req_sel = sel_q;
        if (state_q == StIdle) begin
            req_we  = wb_we_i;
            req_adr = wb_adr_i[23:2];
            req_dat = wb_dat_i;
            req_sel = wb_sel_i;
        end
    end

    assign request   = wb_cyc_i && wb_stb_i;
    assign need_hi   = !req_we || (req_sel[3:2] != 2'b00);
    assign need_lo   = !req_we || (req_sel[1:0] != 2'b00);
    assign next_half = ((state_q == StIdle) && need_hi) ? HALF_HI : HALF_LO;
    assign acc_sel   = (next_half == HALF_HI) ? req_sel[3:2] : req_sel[1:0];
    assign acc_be_n  = req_we ? ~acc_sel : 2'b00;
    assign acc_dat   = (next_half == HALF_HI) ? req_dat[31:16] : req_dat[15:0];

    assign launch = ((state_q == StIdle) && request && (need_hi || need_lo)) ||
                    ((state_q == StGap) && !abort_q && (half_q == HALF_HI) && need_lo);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StInit;
            wait_q     <= 4'd0;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            half_q     <= HALF_HI;
            abort_q    <= 1'b0;
            ack_q      <= 1'b0;
            rdat_q     <= '0;
            sram_adr_q <= '0;
            be_n_q     <= 2'b11;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            dout_q     <= '0;
            doe_q      <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                StInit: begin
                    if (pwr_expire) begin
                        state_q <= StIdle;
                    end
                end
                StIdle: begin
                    if (request) begin
                        adr_q   <= wb_adr_i[23:2];
                        dat_q   <= wb_dat_i;
                        sel_q   <= wb_sel_i;
                        we_q    <= wb_we_i;
                        abort_q <= 1'b0;
                        if (need_hi || need_lo) begin
                            state_q <= StAcc;
                        end else begin
                            ack_q   <= 1'b1;
                            state_q <= StAck;
                        end
                    end
                end
                StAcc: begin
                    // A dropped cycle lets the current half finish its timing.
                    if (!wb_cyc_i) begin
                        abort_q <= 1'b1;
                    end
                    if (wait_q == 4'd0) begin
                        if (!we_q) begin
                            if (half_q == HALF_HI) begin
                                rdat_q[31:16] <= sram_dat;
                            end else begin
                                rdat_q[15:0] <= sram_dat;
                            end
                        end
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        be_n_q  <= 2'b11;
                        doe_q   <= 1'b0;
                        state_q <= StGap;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                StGap: begin
                    if (abort_q) begin
                        state_q <= StIdle;
                    end else if (launch) begin
                        state_q <= StAcc;
                    end else begin
                        ack_q   <= 1'b1;
                        state_q <= StAck;
                    end
                end
                StAck: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StInit;
                end
            endcase

            if (launch) begin
                half_q     <= next_half;
                wait_q     <= WAIT_LOAD;
                sram_adr_q <= {req_adr, next_half};
                ce_n_q     <= 1'b0;
                oe_n_q     <= req_we;
                we_n_q     <= !req_we;
                be_n_q     <= acc_be_n;
                dout_q     <= acc_dat;
                doe_q      <= req_we;
            end
        end
    end

    assign sram_dat   = doe_q ? dout_q : 16'bz;
    assign wb_dat_o   = rdat_q;
    assign wb_ack_o   = ack_q;
    assign ready      = pwr_done;
    assign sram_adr   = sram_adr_q;
    assign sram_be_n  = be_n_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_adv_n = 1'b0;
    assign sram_cre   = 1'b0;
    assign sram_clk   = 1'b0;

endmodule

// File: tb/tb_wb_psram_ctrl.sv
// Scoreboard bench for wb_psram_ctrl: the driver pushes expected acks and
// expected PSRAM accesses; two monitors pop and compare as the DUT responds.
module tb_wb_psram_ctrl;

    localparam int unsigned WC = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        ready;
    logic [22:0] sram_adr;
    wire  [15:0] sram_dat;
    logic [1:0]  sram_be_n;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_adv_n;
    logic        sram_cre;
    logic        sram_clk;

    logic [15:0] mem [0:255];

    // PSRAM model drives the bus only during a read strobe.
    assign sram_dat = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_adr[7:0]] : 16'bz;

    wb_psram_ctrl #(
        .clk_freq    (50000000),
        .powerup_us  (1),
        .wait_cycles (WC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_sel_i   (wb_sel_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .ready      (ready),
        .sram_adr   (sram_adr),
        .sram_dat   (sram_dat),
        .sram_be_n  (sram_be_n),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_adv_n (sram_adv_n),
        .sram_cre   (sram_cre),
        .sram_clk   (sram_clk)
    );

    always #10 clk = ~clk;

    // Edge 1 is the first rising edge after reset release.
    int edge_no;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_no <= 0;
        else          edge_no <= edge_no + 1;
    end

    typedef struct {
        int          edge_n;
        bit          rd;
        logic [31:0] dat;
    } ack_t;

    typedef struct {
        bit          we;
        logic [22:0] adr;
        logic [1:0]  be_n;
        logic [15:0] dat;
    } acc_t;

    ack_t ack_q[$];
    acc_t acc_q[$];
    int   checks = 0;
    int   errors = 0;
    int   z_viol = 0;
    int   early_strobe = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic bit bus_driven();
        return (sram_dat !== 16'hzzzz) && (sram_dat !== 16'h0000);
    endfunction

    // Ack monitor.
    always @(negedge clk) begin
        ack_t e;
        if (reset_n && wb_ack_o) begin
            if (ack_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = ack_q.pop_front();
                check("ack_edge", edge_no, e.edge_n);
                if (e.rd) check("read_data", wb_dat_o, e.dat);
            end
        end
    end

    // PSRAM access monitor: one record per CE-low window.
    logic prev_ce_n = 1'b1;
    acc_t cur;
    bit   cur_oe;
    int   cur_len;
    always @(negedge clk) begin
        acc_t e;
        if (!reset_n) begin
            prev_ce_n = 1'b1;
        end else begin
            if (!sram_ce_n) begin
                if (!ready) early_strobe++;
                if (prev_ce_n) begin
                    cur.we   = !sram_we_n;
                    cur.adr  = sram_adr;
                    cur.be_n = sram_be_n;
                    cur.dat  = cur.we ? sram_dat : 16'h0000;
                    cur_oe   = !sram_oe_n;
                    cur_len  = 1;
                end else begin
                    cur_len++;
                end
            end else begin
                if (bus_driven()) z_viol++;
                if (!prev_ce_n) begin
                    if (acc_q.size() == 0) begin
                        check("unexpected_access", {9'd0, cur.adr}, 32'hffffffff);
                    end else begin
                        e = acc_q.pop_front();
                        check("acc_we", {31'd0, cur.we}, {31'd0, e.we});
                        check("acc_oe", {31'd0, cur_oe}, {31'd0, !e.we});
                        check("acc_adr", {9'd0, cur.adr}, {9'd0, e.adr});
                        check("acc_be_n", {30'd0, cur.be_n}, {30'd0, e.be_n});
                        check("acc_len", cur_len, WC);
                        if (e.we) check("acc_wdata", {16'd0, cur.dat}, {16'd0, e.dat});
                    end
                    if (cur.we) begin
                        if (!cur.be_n[1]) mem[cur.adr[7:0]][15:8] = cur.dat[15:8];
                        if (!cur.be_n[0]) mem[cur.adr[7:0]][7:0]  = cur.dat[7:0];
                    end
                end
            end
            prev_ce_n = sram_ce_n;
        end
    end

    task automatic exp_acc(input bit we, input logic [22:0] adr, input logic [1:0] be_n,
                           input logic [15:0] dat);
        acc_t a;
        a.we = we; a.adr = adr; a.be_n = be_n; a.dat = dat;
        acc_q.push_back(a);
    endtask

    // Issue one cycle; ack is expected halves*(WC+1) edges after the sampling edge.
    task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int halves, input logic [31:0] rexp);
        ack_t a;
        bit   got;
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        a.edge_n = edge_no + 1 + halves * (WC + 1);
        a.rd = !we;
        a.dat = rexp;
        ack_q.push_back(a);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (wb_ack_o) got = 1'b1;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        if (!got) check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_ready();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (ready) got = 1'b1;
        end
        check("ready_edge", got ? edge_no : -1, 32'd50);
    endtask

    initial begin
        ack_t a;
        bit   got;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'h1357;
        mem[1] = 16'h9bdf;

        // Reset state, with a read request already held on the bus.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = 32'h4000_0000; wb_sel_i = 4'hf;
        #25;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check("rst_dat_o", wb_dat_o, 32'd0);
        check("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
        check("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("rst_be_n", {30'd0, sram_be_n}, 32'd3);
        check("rst_adr", {9'd0, sram_adr}, 32'd0);
        check("rst_static", {29'd0, sram_adv_n, sram_cre, sram_clk}, 32'd0);
        check("rst_dat_z", {31'd0, bus_driven()}, 32'd0);

        // Held request: ready at edge 50 (IDLE at the same edge), sampled at 51, ack at 61.
        exp_acc(1'b0, 23'd0, 2'b00, 16'h0);
        exp_acc(1'b0, 23'd1, 2'b00, 16'h0);
        a.edge_n = 61; a.rd = 1'b1; a.dat = 32'h1357_9bdf;
        ack_q.push_back(a);
        #15 reset_n = 1'b1;
        wait_ready();
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (wb_ack_o) got = 1'b1;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        if (!got) check("held_ack_timeout", 32'd0, 32'd1);

        // Full write then read back; byte address 0x10 -> halfwords 8 and 9.
        exp_acc(1'b1, 23'd8, 2'b00, 16'hdead);
        exp_acc(1'b1, 23'd9, 2'b00, 16'hbeef);
        xfer(1'b1, 32'h4000_0010, 32'hdead_beef, 4'b1111, 2, 32'h0);
        exp_acc(1'b0, 23'd8, 2'b00, 16'h0);
        exp_acc(1'b0, 23'd9, 2'b00, 16'h0);
        xfer(1'b0, 32'h4000_0010, 32'h0, 4'b1111, 2, 32'hdead_beef);

        // Lower-half-only write, then read back both halves.
        exp_acc(1'b1, 23'h11, 2'b00, 16'habcd);
        xfer(1'b1, 32'h4000_0020, 32'h1234_abcd, 4'b0011, 1, 32'h0);
        exp_acc(1'b0, 23'h10, 2'b00, 16'h0);
        exp_acc(1'b0, 23'h11, 2'b00, 16'h0);
        xfer(1'b0, 32'h4000_0020, 32'h0, 4'b1111, 2, 32'h0000_abcd);

        // Single byte in the upper half, then an empty-select write.
        exp_acc(1'b1, 23'h18, 2'b01, 16'hcafe);
        xfer(1'b1, 32'h4000_0030, 32'hcafe_0000, 4'b1000, 1, 32'h0);
        xfer(1'b1, 32'h4000_0034, 32'hffff_ffff, 4'b0000, 0, 32'h0);
        exp_acc(1'b0, 23'h18, 2'b00, 16'h0);
        exp_acc(1'b0, 23'h19, 2'b00, 16'h0);
        xfer(1'b0, 32'h4000_0030, 32'h0, 4'b1111, 2, 32'hca00_0000);

        // Abort: drop cyc after edge 2 of a read; only the upper half runs, no ack.
        exp_acc(1'b0, 23'd8, 2'b00, 16'h0);
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = 32'h4000_0010; wb_sel_i = 4'hf;
        repeat (3) @(negedge clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_acc_pending", acc_q.size(), 32'd0);
        check("abort_ack_pending", ack_q.size(), 32'd0);
        exp_acc(1'b0, 23'h10, 2'b00, 16'h0);
        exp_acc(1'b0, 23'h11, 2'b00, 16'h0);
        xfer(1'b0, 32'h4000_0020, 32'h0, 4'b1111, 2, 32'h0000_abcd);

        // Reset in the middle of a write access.
        @(negedge clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 32'h4000_0040; wb_dat_i = 32'h55aa_33cc; wb_sel_i = 4'hf;
        repeat (3) @(posedge clk);
        #2;
        check("pre_reset_we_n", {31'd0, sram_we_n}, 32'd0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
        check("mid_rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("mid_rst_be_n", {30'd0, sram_be_n}, 32'd3);
        check("mid_rst_dat_z", {31'd0, bus_driven()}, 32'd0);
        check("mid_rst_ready", {31'd0, ready}, 32'd0);
        check("mid_rst_dat_o", wb_dat_o, 32'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_ready();

        exp_acc(1'b0, 23'd8, 2'b00, 16'h0);
        exp_acc(1'b0, 23'd9, 2'b00, 16'h0);
        xfer(1'b0, 32'h4000_0010, 32'h0, 4'b1111, 2, 32'hdead_beef);

        repeat (5) @(negedge clk);
        check("ack_queue_empty", ack_q.size(), 32'd0);
        check("acc_queue_empty", acc_q.size(), 32'd0);
        check("bus_driven_outside_acc", z_viol, 32'd0);
        check("strobe_before_ready", early_strobe, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
